div_seq_ctrl: RTL and testbench

Sequencer for the CPU's iterative 32-bit divider. It accepts DIV/DIVU requests from the execute stage and runs a 32-iteration restoring shift-subtract sequence with sign pre- and post-processing. It stalls the pipeline while the division is in flight, then presents HI (remainder) and LO (quotient) until the pipeline accepts them. It sits beside the ALU in the E stage and feeds the HI/LO write path.

---
 rtl/div_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_div_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - iterative 32-bit DIV/DIVU sequencer (restoring, 1 bit per cycle)
// Optional macro DIV_ZERO_FAST_EN: divisor 0 short-circuits PREP straight to DONE.
module div_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        accept,
    input  logic        annul,
    output logic        stall,
    output logic        busy,
    output logic        ready,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_CALC  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, b_q, dvs_q, hi_q, lo_q;
    logic        sgn_q, neg_quo_q, neg_rem_q;
    logic [63:0] rq_q;
    logic [4:0]  cnt_q;

    logic [31:0] a_abs, b_abs, rem_sub;
    logic [32:0] top33;
    logic        ge;
    logic [63:0] rq_step;

`ifdef DIV_ZERO_FAST_EN
    logic b_zero;
    assign b_zero = (b_q == 32'd0);
`endif

    assign a_abs = neg_rem_q ? (~a_q + 32'd1) : a_q;
    assign b_abs = (sgn_q & b_q[31]) ? (~b_q + 32'd1) : b_q;

    // After the shift the partial remainder is 33 bits; the difference always fits in 32.
    assign top33   = rq_q[63:31];
    assign ge      = (top33 >= {1'b0, dvs_q});
    assign rem_sub = rq_q[62:31] - dvs_q;
    assign rq_step = ge ? {rem_sub, rq_q[30:0], 1'b1} : {rq_q[62:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (annul) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_PREP;
                S_PREP: begin
                    state_d = S_CALC;
`ifdef DIV_ZERO_FAST_EN
                    if (b_zero) state_d = S_DONE;
`endif
                end
                S_CALC:  if (cnt_q == 5'd31) state_d = S_FIXUP;
                S_FIXUP: state_d = S_DONE;
                S_DONE:  if (accept) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall = start && (state_q != S_DONE);
        busy  = (state_q != S_IDLE);
        ready = (state_q == S_DONE);
    end

    // HI/LO are only written on entry to DONE, so an annul leaves the old result visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            sgn_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvs_q     <= 32'd0;
            rq_q      <= 64'd0;
            cnt_q     <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !annul) begin
                        a_q       <= a;
                        b_q       <= b;
                        sgn_q     <= signed_div;
                        neg_quo_q <= signed_div & (a[31] ^ b[31]);
                        neg_rem_q <= signed_div & a[31];
                    end
                end
                S_PREP: begin
                    dvs_q <= b_abs;
                    rq_q  <= {32'd0, a_abs};
                    cnt_q <= 5'd0;
`ifdef DIV_ZERO_FAST_EN
                    if (b_zero && !annul) begin
                        hi_q <= a_q;
                        lo_q <= 32'hFFFF_FFFF;
                    end
`endif
                end
                S_CALC: begin
                    rq_q  <= rq_step;
                    cnt_q <= cnt_q + 5'd1;
                end
                S_FIXUP: begin
                    if (!annul) begin
                        lo_q <= neg_quo_q ? (~rq_q[31:0] + 32'd1) : rq_q[31:0];
                        hi_q <= neg_rem_q ? (~rq_q[63:32] + 32'd1) : rq_q[63:32];
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - self-checking bench for div_seq_ctrl (directed + random vs. arithmetic model)
module tb_div_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        accept;
    logic        annul;
    logic        stall;
    logic        busy;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total = 0;
    int n_pass  = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 34;
`endif

    div_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .accept     (accept),
        .annul      (annul),
        .stall      (stall),
        .busy       (busy),
        .ready      (ready),
        .hi         (hi),
        .lo         (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Result as {hi, lo} straight from the arithmetic definition of DIV/DIVU.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ux, uy, q, r;
        logic        nx, ny;
`ifdef DIV_ZERO_FAST_EN
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
`endif
        nx = s & x[31];
        ny = s & y[31];
        ux = nx ? (32'd0 - x) : x;
        uy = ny ? (32'd0 - y) : y;
        if (uy == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ux;
        end else begin
            q = ux / uy;
            r = ux % uy;
        end
        return {(nx ? (32'd0 - r) : r), ((nx ^ ny) ? (32'd0 - q) : q)};
    endfunction

    // Transaction-level model: a countdown until the result appears, then a hold until accept.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_rem  = 0;
    logic [63:0] m_pend = 64'd0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_rem  <= 0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
        end else if (annul) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_pend <= ref_div(signed_div, a, b);
`ifdef DIV_ZERO_FAST_EN
                m_rem  <= (b == 32'd0) ? 1 : 34;
`else
                m_rem  <= 34;
`endif
            end
        end else if (!m_done) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_done <= 1'b1;
                m_hi   <= m_pend[63:32];
                m_lo   <= m_pend[31:0];
            end
        end else if (accept) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("stall", {31'd0, stall}, {31'd0, start & ~m_done});
        chk("busy",  {31'd0, busy},  {31'd0, m_busy});
        chk("ready", {31'd0, ready}, {31'd0, m_done});
        chk("hi",    hi, m_hi);
        chk("lo",    lo, m_lo);
    end

    task automatic do_op(input string nm, input logic s, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ehi, input logic [31:0] elo, input int elat, input int nwait);
        int lat;
        @(posedge clk); #1;
        start      = 1'b1;
        signed_div = s;
        a          = av;
        b          = bv;
        accept     = (nwait == 0);
        @(posedge clk); #1;
        // operands are latched at this edge; later changes must not matter
        a          = $urandom;
        b          = $urandom;
        signed_div = 1'($urandom_range(0, 1));
        lat = 0;
        while (!ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(elat));
        chk({nm, " lo"}, lo, elo);
        chk({nm, " hi"}, hi, ehi);
        for (int i = 0; i < nwait; i++) begin
            chk({nm, " held ready"}, {31'd0, ready}, 32'd1);
            chk({nm, " held lo"}, lo, elo);
            @(posedge clk); #1;
        end
        accept = 1'b1;
        @(posedge clk); #1;
        chk({nm, " idle after accept"}, {31'd0, busy}, 32'd0);
        start  = 1'b0;
        accept = 1'b0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = 32'd0; b = 32'd0;
        accept = 1'b0; annul = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset ready", {31'd0, ready}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);

        do_op("divu 100/7",  1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         34,   0);
        do_op("div -7/2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  34,   0);
        do_op("div min/-1",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  34,   0);
        do_op("divu x/0",    1'b0, 32'h1234_5678,  32'd0,          32'h1234_5678,  32'hFFFF_FFFF,  ZLAT, 0);
        do_op("divu 9/4",    1'b0, 32'd9,          32'd4,          32'd1,          32'd2,          34,   5);

        // annul mid-calculation, then reissue the same instruction
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b1; a = 32'd50; b = 32'd5;
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        chk("annul busy", {31'd0, busy}, 32'd0);
        chk("annul ready", {31'd0, ready}, 32'd0);
        chk("annul keeps hi", hi, 32'd1);
        chk("annul keeps lo", lo, 32'd2);
        @(posedge clk); #1;
        lat = 0;
        while (!ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("reissue latency", 32'(lat), 32'd34);
        chk("reissue lo", lo, 32'd10);
        chk("reissue hi", hi, 32'd0);
        accept = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; accept = 1'b0;

        // asynchronous reset in the middle of CALC
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd3;
        repeat (15) @(posedge clk);
        #3;
        start = 1'b0;
        rst   = 1'b1;
        #1;
        chk("async rst busy", {31'd0, busy}, 32'd0);
        chk("async rst stall", {31'd0, stall}, 32'd0);
        chk("async rst ready", {31'd0, ready}, 32'd0);
        chk("async rst hi", hi, 32'd0);
        chk("async rst lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start      = ($urandom_range(0, 9) != 0);
            accept     = ($urandom_range(0, 3) == 0);
            annul      = ($urandom_range(0, 199) == 0);
            signed_div = 1'($urandom_range(0, 1));
            a          = rnd_val();
            b          = rnd_val();
        end
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0; accept = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
